// File: rtl/zxuno_string_reader.sv
// ZX-UNO register-read initiator: fetches a zero-terminated string from one
// register into a 16-byte buffer. The buffer has a random-access read port.

module zxuno_strbuf_cell (
    input  logic       clk,
    input  logic       clr,
    input  logic       we,
    input  logic [7:0] d,
    output logic [7:0] q
);
    always_ff @(posedge clk) begin
        if (clr)     q <= 8'h00;
        else if (we) q <= d;
    end
endmodule

module zxuno_string_reader #(
    parameter logic [7:0] REGADDR     = 8'hFF,
    parameter int         MAXLEN      = 16,
    parameter int         READ_CYCLES = 2,
    parameter int         GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [4:0] len,
    output logic [7:0] zxuno_addr,
    output logic       regaddr_changed,
    output logic       zxuno_regrd,
    input  logic [7:0] din,
    input  logic       oe_n_in,
    input  logic [3:0] rd_index,
    output logic [7:0] rd_data
);
    localparam int NUM_ENTRIES = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SETTLE, S_READ, S_GAP, S_DONE
    } state_t;

    state_t state, state_n;

    logic [7:0]                        cnt;
    logic                              term_seen;
    logic                              accept;
    logic                              last_read;
    logic                              last_gap;
    logic                              stop;
    logic                              wr_en;
    logic [NUM_ENTRIES-1:0][7:0]       buf_q;

    assign accept    = (state == S_IDLE) && start;
    assign last_read = (state == S_READ) && (cnt == 8'(READ_CYCLES - 1));
    assign last_gap  = (state == S_GAP)  && (cnt == 8'(GAP_CYCLES - 1));
    // Flags sampled on the last READ cycle are already registered by GAP.
    assign stop      = term_seen || error || (len == 5'(MAXLEN));
    assign wr_en     = last_read && !oe_n_in && (din != 8'h00) && (len < 5'(MAXLEN));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = S_SELECT;
            S_SELECT: state_n = S_SETTLE;
            S_SETTLE: state_n = S_READ;
            S_READ:   if (last_read) state_n = S_GAP;
            S_GAP:    if (last_gap) state_n = stop ? S_DONE : S_READ;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Phase counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst || state_n != state) cnt <= 8'd0;
        else                         cnt <= cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            len       <= 5'd0;
            error     <= 1'b0;
            term_seen <= 1'b0;
        end else if (last_read) begin
            if (oe_n_in)           error     <= 1'b1;
            else if (din == 8'h00) term_seen <= 1'b1;
            else if (wr_en)        len       <= len + 5'd1;
        end
    end

    // Outputs registered from next state so they line up with the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            regaddr_changed <= 1'b0;
            zxuno_regrd     <= 1'b0;
            zxuno_addr      <= 8'h00;
        end else begin
            busy            <= (state_n != S_IDLE);
            done            <= (state_n == S_DONE);
            regaddr_changed <= (state_n == S_SELECT);
            zxuno_regrd     <= (state_n == S_READ);
            zxuno_addr      <= (state_n != S_IDLE) ? REGADDR : 8'h00;
        end
    end

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_buf
        zxuno_strbuf_cell u_cell (
            .clk (clk),
            .clr (rst || accept),
            .we  (wr_en && (len[3:0] == 4'(i))),
            .d   (din),
            .q   (buf_q[i])
        );
    end

    assign rd_data = ({1'b0, rd_index} < len) ? buf_q[rd_index] : 8'h00;

endmodule

// File: tb/tb_zxuno_string_reader.sv
// Directed bench for zxuno_string_reader with a behavioural string responder.

module tb_zxuno_string_reader;
    localparam logic [7:0] REGADDR = 8'hFF;

    logic       clk = 1'b0;
    logic       rst, start, oe_n_in;
    logic [7:0] din;
    logic [3:0] rd_index;
    logic       busy, done, error, regaddr_changed, zxuno_regrd;
    logic [4:0] len;
    logic [7:0] zxuno_addr, rd_data;

    zxuno_string_reader dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .error(error), .len(len), .zxuno_addr(zxuno_addr),
        .regaddr_changed(regaddr_changed), .zxuno_regrd(zxuno_regrd),
        .din(din), .oe_n_in(oe_n_in), .rd_index(rd_index), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: index resets on regaddr_changed, advances on strobe release.
    logic [7:0] pat [0:31];
    logic [4:0] idx = 5'd0;
    logic       regrd_d = 1'b0;
    always @(posedge clk) begin
        regrd_d <= zxuno_regrd;
        if (regaddr_changed)             idx <= 5'd0;
        else if (regrd_d && !zxuno_regrd) idx <= idx + 5'd1;
    end
    assign din = (zxuno_addr == REGADDR) ? pat[idx] : 8'h00;

    int   n_strobe = 0, n_rc = 0;
    logic regrd_n = 1'b0;
    always @(negedge clk) begin
        if (zxuno_regrd && !regrd_n) n_strobe = n_strobe + 1;
        if (regaddr_changed)         n_rc = n_rc + 1;
        regrd_n = zxuno_regrd;
    end

    int checks = 0, errors = 0;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic load_pat(input int p);
        string s;
        s = "T19-15112015";
        for (int i = 0; i < 32; i++) pat[i] = 8'h00;
        case (p)
            0: for (int i = 0; i < s.len(); i++) pat[i] = s[i];
            1: begin
                for (int i = 0; i < 16; i++) pat[i] = 8'h41 + 8'(i);
                pat[16] = 8'h51;
                pat[17] = 8'h52;
            end
            3: pat[0] = 8'h41;
            default: ;
        endcase
    endtask

    typedef struct {
        int pat; bit oe_hi; int done_c; int strobes; int len; bit err;
    } vec_t;
    typedef struct { int vec; int idx; int exp; } rd_t;

    vec_t vecs [5];
    rd_t  rds  [8];
    int   t0, done_c;
    bit   prev_err;

    task automatic start_run();
        n_strobe = 0;
        n_rc     = 0;
        @(negedge clk);
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input bit poke_start);
        done_c = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin
                done_c = cyc - t0;
                start  = 1'b0;
                break;
            end
            start = poke_start && ((cyc - t0 == 5) || (cyc - t0 == 20));
        end
        start = 1'b0;
        if (done_c < 0) $display("FAIL done_timeout: got none expected done within 200 cycles");
    endtask

    initial begin
        vecs[0] = '{0, 1'b0, 42, 13, 12, 1'b0};
        vecs[1] = '{1, 1'b0, 51, 16, 16, 1'b0};
        vecs[2] = '{2, 1'b0,  6,  1,  0, 1'b0};
        vecs[3] = '{3, 1'b1,  6,  1,  0, 1'b1};
        vecs[4] = '{0, 1'b0, 42, 13, 12, 1'b0};
        rds[0] = '{0,  0, 'h54};
        rds[1] = '{0, 11, 'h35};
        rds[2] = '{0, 12, 'h00};
        rds[3] = '{1, 15, 'h50};
        rds[4] = '{1,  0, 'h41};
        rds[5] = '{2,  0, 'h00};
        rds[6] = '{3,  0, 'h00};
        rds[7] = '{4,  1, 'h31};

        rst = 1'b1; start = 1'b0; oe_n_in = 1'b0; rd_index = 4'd0;
        load_pat(0);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_len", len, 0);
        chk("rst_addr", zxuno_addr, 0);
        chk("rst_rc", regaddr_changed, 0);
        chk("rst_regrd", zxuno_regrd, 0);
        #1 chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        prev_err = 1'b0;

        for (int v = 0; v < 5; v++) begin
            load_pat(vecs[v].pat);
            oe_n_in = vecs[v].oe_hi;
            chk($sformatf("v%0d_err_idle", v), error, prev_err);
            start_run();
            chk($sformatf("v%0d_rc_c1", v), regaddr_changed, 1);
            chk($sformatf("v%0d_busy_c1", v), busy, 1);
            chk($sformatf("v%0d_addr_c1", v), zxuno_addr, REGADDR);
            chk($sformatf("v%0d_err_c1", v), error, 0);
            wait_done(1'b0);
            chk($sformatf("v%0d_done_cyc", v), done_c, vecs[v].done_c);
            chk($sformatf("v%0d_strobes", v), n_strobe, vecs[v].strobes);
            chk($sformatf("v%0d_rc_count", v), n_rc, 1);
            chk($sformatf("v%0d_len", v), len, vecs[v].len);
            chk($sformatf("v%0d_error", v), error, vecs[v].err);
            @(negedge clk);
            chk($sformatf("v%0d_busy_after", v), busy, 0);
            chk($sformatf("v%0d_done_after", v), done, 0);
            for (int r = 0; r < 8; r++) begin
                if (rds[r].vec == v) begin
                    rd_index = 4'(rds[r].idx);
                    #1 chk($sformatf("v%0d_rd_data_%0d", v, rds[r].idx), rd_data, rds[r].exp);
                end
            end
            prev_err = vecs[v].err;
            oe_n_in  = 1'b0;
        end

        // Reset during a read.
        load_pat(0);
        start_run();
        for (int k = 0; k < 20 && (cyc - t0 < 10); k++) @(negedge clk);
        chk("mid_len_c10", len, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_regrd", zxuno_regrd, 0);
        chk("mid_len", len, 0);
        chk("mid_error", error, 0);
        rd_index = 4'd0;
        #1 chk("mid_rd_data", rd_data, 0);
        rst  = 1'b0;
        n_rc = 0;
        repeat (3) @(negedge clk);
        chk("mid_no_rc", n_rc, 0);

        // Restart with start pulses while busy.
        start_run();
        wait_done(1'b1);
        chk("busy_start_done_cyc", done_c, 42);
        chk("busy_start_rc_count", n_rc, 1);
        chk("busy_start_strobes", n_strobe, 13);
        chk("busy_start_len", len, 12);
        @(negedge clk);
        chk("busy_start_idle", busy, 0);
        rd_index = 4'd11;
        #1 chk("busy_start_rd_11", rd_data, 'h35);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/zxuno_string_reader.md
# zxuno_string_reader

Initiator for the ZX-UNO register read protocol, the consumer side of string-returning registers such as the core-ID register. On a start request it selects a register address, issues successive read strobes and captures one byte per strobe into a 16-entry buffer. It stops at the first 0x00 byte or after MAXLEN bytes. It sits beside the register decoder and lets on-chip logic (boot/status logic, OSD) fetch the core identification string without CPU involvement.

## Interface
- REGADDR, 8'hFF: register address selected for the string read.
- MAXLEN, 16: maximum bytes captured. Range 1..16.
- READ_CYCLES, 2: cycles zxuno_regrd is held high per byte. Must be at least 1.
- GAP_CYCLES, 1: cycles zxuno_regrd is held low between bytes. Must be at least 1, because the responder advances its index on strobe release.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a string read; sampled only in IDLE
- busy  out  1  high from SELECT through DONE inclusive
- done  out  1  one-cycle pulse in DONE
- error  out  1  responder did not drive data (oe_n_in high at sample); held until next accepted start
- len  out  5  number of non-zero bytes captured (0..16)
- zxuno_addr  out  8  register address to responder; REGADDR while busy, 8'h00 otherwise
- regaddr_changed  out  1  one-cycle pulse in SELECT
- zxuno_regrd  out  1  read strobe
- din  in  8  responder data
- oe_n_in  in  1  responder output-enable, active low
- rd_index  in  4  buffer read address
- rd_data  out  8  buffer[rd_index], combinational; 8'h00 for index ≥ len

## Operation
- States: IDLE, SELECT, SETTLE, READ, GAP, DONE.
- IDLE:
  - start=1 → clear buffer, len and error; go to SELECT.
- SELECT (1 cycle):
  - zxuno_addr=REGADDR and regaddr_changed=1, which resets the responder's index.
  - Then go to SETTLE.
- SETTLE (1 cycle):
  - Address held, strobe low.
  - Then go to READ.
- READ (READ_CYCLES cycles):
  - zxuno_regrd=1.
  - On the last READ cycle, sample din and oe_n_in.
  - oe_n_in=1 → set error; go to DONE after GAP.
  - din≠0 → write buffer[len] and increment len.
  - din=0 → stop: the terminator is not stored.
- GAP (GAP_CYCLES cycles):
  - zxuno_regrd=0.
  - Then go to DONE if any of these holds: a terminator was seen, error is set, or len==MAXLEN.
  - Otherwise go back to READ.
- DONE (1 cycle):
  - done=1, then return to IDLE.
- start while busy is ignored.
- No wrap-around: capture always stops at MAXLEN, so len never exceeds 16.
- Reset mid-operation:
  - Next cycle is IDLE with strobe low, buffer cleared, len=0 and error=0.
  - No regaddr_changed is issued by reset.

## Timing
- Reset values: busy=0, done=0, error=0, len=0, zxuno_addr=8'h00, regaddr_changed=0, zxuno_regrd=0, every buffer entry 8'h00.
- All outputs except rd_data are registered.
- Let R=READ_CYCLES, G=GAP_CYCLES, P=R+G. Start is sampled at cycle 0.
  - SELECT is cycle 1 and SETTLE is cycle 2.
  - Byte k: strobe is high in cycles 3+kP .. 3+kP+R-1, and din is sampled in cycle 3+kP+R-1.
  - After N strobes (including the terminator or the abort), done pulses in cycle 3+N·P.
  - busy falls in the following cycle.
- len and the buffer entry update in the cycle after the sample.
- Final len is stable when done is high.

## Test plan
- Responder model returns "T19-15112015" then 0x00; defaults (R=2, G=1); start at cycle 0:
  - regaddr_changed pulses at cycle 1.
  - 13 strobes occur.
  - done pulses at cycle 42.
  - len=12, rd_data at index 0 = 0x54, at index 11 = 0x35, at index 12 = 0x00.
  - error=0.
- Responder returns 16 non-zero bytes 0x41..0x50:
  - 16 strobes, done at cycle 51.
  - len=16, rd_data at index 15 = 0x50.
- Responder returns 0x00 first:
  - One strobe, done at cycle 6, len=0.
- oe_n_in held high:
  - done at cycle 6, error=1, len=0.
  - The next start clears error.
- rst asserted at cycle 10 of a read:
  - Next cycle: busy=0, zxuno_regrd=0, len=0.
  - start pulses during busy produce no restart; the second run then completes normally.
